// File: rtl/alarm_clock_core.sv
// Alarm clock core: keeps BCD HH:MM:SS from a divided 1 s tick, holds an alarm HH:MM,
// and runs the ring/snooze FSM.
// Ports:
//   clk, reset (async, active-high)
//   mode[1:0]: 00 run, 01 set time, 10 set alarm, 11 run
//   inc_hr / inc_min: edit pulses; alarm_en: armed level
//   snooze / stop: ring control pulses
//   hh_bcd, mm_bcd, ss_bcd: displayed digits {tens,units}
//   sec_tick: one-cycle pulse per second; ringing: high while RINGING
// Build option: define ALARM_SNOOZE_EN to enable the snooze input and the SNOOZED state.
module alarm_clock_core #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int HOURS_MAX  = 24,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       sec_tick,
    output logic       ringing
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [7:0] HH_LAST =
        {4'((HOURS_MAX - 1) / 10), 4'((HOURS_MAX - 1) % 10)};
    localparam logic [7:0] MS_LAST = 8'h59;
    localparam logic [5:0] RING_LAST = 6'(RING_MIN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
        ,
        SNOOZED = 2'd2
`endif
    } state_t;

    logic [DW-1:0] div;
    logic [7:0]    hh, mm, ss;
    logic [7:0]    al_hh, al_mm;
    logic          set_time, set_alarm;
    logic          tick_now, min_carry, match;
    state_t        state;
    logic [5:0]    mins;

    // BCD increment with wrap to 00 after the given last value.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] last);
        if (v == last)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign set_time  = (mode == 2'b01);
    assign set_alarm = (mode == 2'b10);
    assign tick_now  = !set_time && (div == DIV_LAST);
    assign min_carry = tick_now && (ss == MS_LAST);

    // sec_tick is registered together with the time update, so it being high
    // means the displayed time was just reached by a tick (not by editing).
    assign match = sec_tick && !set_time && alarm_en &&
                   (hh == al_hh) && (mm == al_mm) && (ss == 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            sec_tick <= 1'b0;
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
            al_hh    <= 8'h00;
            al_mm    <= 8'h00;
        end else if (set_time) begin
            div      <= '0;
            sec_tick <= 1'b0;
            ss       <= 8'h00;
            if (inc_min)
                mm <= bcd_inc(mm, MS_LAST);
            if (inc_hr)
                hh <= bcd_inc(hh, HH_LAST);
        end else begin
            sec_tick <= tick_now;
            div      <= tick_now ? '0 : div + DW'(1);
            if (tick_now) begin
                ss <= bcd_inc(ss, MS_LAST);
                if (ss == MS_LAST) begin
                    mm <= bcd_inc(mm, MS_LAST);
                    if (mm == MS_LAST)
                        hh <= bcd_inc(hh, HH_LAST);
                end
            end
            if (set_alarm) begin
                if (inc_min)
                    al_mm <= bcd_inc(al_mm, MS_LAST);
                if (inc_hr)
                    al_hh <= bcd_inc(al_hh, HH_LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ringing <= 1'b0;
            mins    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match) begin
                        state   <= RINGING;
                        ringing <= 1'b1;
                        mins    <= '0;
                    end
                end
                RINGING: begin
                    if (stop || !alarm_en) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                        mins    <= '0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state   <= SNOOZED;
                        ringing <= 1'b0;
                        mins    <= '0;
`endif
                    end else if (min_carry) begin
                        if (mins + 6'd1 == RING_LAST) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                            mins    <= '0;
                        end else begin
                            mins <= mins + 6'd1;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZED: begin
                    if (stop || !alarm_en) begin
                        state <= IDLE;
                        mins  <= '0;
                    end else if (min_carry) begin
                        if (mins + 6'd1 == 6'(SNOOZE_MIN)) begin
                            state   <= RINGING;
                            ringing <= 1'b1;
                            mins    <= '0;
                        end else begin
                            mins <= mins + 6'd1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
                    mins    <= '0;
                end
            endcase
        end
    end

`ifndef ALARM_SNOOZE_EN
    // Snooze hardware is absent in this build.
    logic [6:0] unused_snooze;
    assign unused_snooze = {snooze, 6'(SNOOZE_MIN)};
`endif

    always_comb begin
        hh_bcd = hh;
        mm_bcd = mm;
        ss_bcd = ss;
        if (set_alarm) begin
            hh_bcd = al_hh;
            mm_bcd = al_mm;
            ss_bcd = 8'h00;
        end
    end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Testbench for alarm_clock_core: directed setups plus randomized pulses, with every
// cycle checked against an integer-seconds reference model through a scoreboard queue.
module tb_alarm_clock_core;

    localparam int TD  = 4;
    localparam int HM  = 24;
    localparam int SNZ_MIN = 2;
    localparam int RNG_MIN = 1;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       inc_hr = 1'b0, inc_min = 1'b0;
    logic       alarm_en = 1'b0, snooze = 1'b0, stop = 1'b0;
    logic [7:0] hh_bcd, mm_bcd, ss_bcd;
    logic       sec_tick, ringing;

    alarm_clock_core #(
        .TICK_DIV(TD), .HOURS_MAX(HM),
        .SNOOZE_MIN(SNZ_MIN), .RING_MIN(RNG_MIN)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .inc_hr(inc_hr), .inc_min(inc_min), .alarm_en(alarm_en),
        .snooze(snooze), .stop(stop),
        .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
        .sec_tick(sec_tick), .ringing(ringing)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       tk;
        logic       rg;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   ring_cycles = 0;
    logic ae_lvl = 1'b0;

    // Reference model: time as seconds of day, alarm as minutes of day.
    int m_t, m_al, m_div, m_rs, m_mc;
    bit m_tk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_t = 0; m_al = 0; m_div = 0; m_rs = 0; m_mc = 0; m_tk = 0;
    endtask

    task automatic model_step(input logic [1:0] md, input bit ih, im,
                              input bit ae, sn, sp);
        bit st, sa, tick, carry, match;
        int h, m;
        exp_t e;
        st    = (md == 2'b01);
        sa    = (md == 2'b10);
        tick  = !st && (m_div == TD - 1);
        carry = tick && (m_t % 60 == 59);
        match = m_tk && !st && ae && (m_t == m_al * 60);
        // ring state: 0 idle, 1 ringing, 2 snoozed
        if (m_rs == 0) begin
            if (match) begin m_rs = 1; m_mc = 0; end
        end else if (m_rs == 1) begin
            if (sp || !ae) begin m_rs = 0; m_mc = 0; end
            else if (SNZ && sn) begin m_rs = 2; m_mc = 0; end
            else if (carry) begin
                m_mc++;
                if (m_mc == RNG_MIN) begin m_rs = 0; m_mc = 0; end
            end
        end else begin
            if (sp || !ae) begin m_rs = 0; m_mc = 0; end
            else if (carry) begin
                m_mc++;
                if (m_mc == SNZ_MIN) begin m_rs = 1; m_mc = 0; end
            end
        end
        if (st) begin
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            if (im) m = (m + 1) % 60;
            if (ih) h = (h + 1) % HM;
            m_t = h * 3600 + m * 60;
        end else if (tick) begin
            m_t = (m_t + 1) % (HM * 3600);
        end
        if (sa) begin
            h = m_al / 60;
            m = m_al % 60;
            if (im) m = (m + 1) % 60;
            if (ih) h = (h + 1) % HM;
            m_al = h * 60 + m;
        end
        m_div = st ? 0 : (m_div + 1) % TD;
        m_tk  = tick;
        if (sa) begin
            e.hh = to_bcd(m_al / 60);
            e.mm = to_bcd(m_al % 60);
            e.ss = 8'h00;
        end else begin
            e.hh = to_bcd(m_t / 3600);
            e.mm = to_bcd((m_t / 60) % 60);
            e.ss = to_bcd(m_t % 60);
        end
        e.tk = tick;
        e.rg = (m_rs == 1);
        q.push_back(e);
    endtask

    task automatic step(input logic [1:0] md, input bit ih, im, sn, sp);
        @(negedge clk);
        mode     = md;
        inc_hr   = ih;
        inc_min  = im;
        snooze   = sn;
        stop     = sp;
        alarm_en = ae_lvl;
        model_step(md, ih, im, ae_lvl, sn, sp);
    endtask

    task automatic run(input int n);
        repeat (n) step(2'b00, 0, 0, 0, 0);
    endtask

    // Edit a field pair to (h,m); presses both buttons together while both need steps.
    task automatic edit(input logic [1:0] md, input int h, input int m);
        int ch, cm, dh, dm;
        step(md, 0, 0, 0, 0);
        if (md == 2'b01) begin
            ch = m_t / 3600;
            cm = (m_t / 60) % 60;
        end else begin
            ch = m_al / 60;
            cm = m_al % 60;
        end
        dh = (h - ch + HM) % HM;
        dm = (m - cm + 60) % 60;
        while (dh > 0 || dm > 0) begin
            step(md, dh > 0, dm > 0, 0, 0);
            step(md, 0, 0, 0, 0);
            if (dh > 0) dh--;
            if (dm > 0) dm--;
        end
        step(2'b00, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("hh_bcd", 32'(hh_bcd), 32'(e.hh));
            chk("mm_bcd", 32'(mm_bcd), 32'(e.mm));
            chk("ss_bcd", 32'(ss_bcd), 32'(e.ss));
            chk("sec_tick", 32'(sec_tick), 32'(e.tk));
            chk("ringing", 32'(ringing), 32'(e.rg));
            if (ringing) ring_cycles++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ah, am, tm, n, r;
        bit sp, sn, ih, im;
        logic [1:0] md;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Async reset from a non-zero time and mid-divider.
        edit(2'b01, 5, 7);
        run(10);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_hh", 32'(hh_bcd), 32'h0);
        chk("rst_mm", 32'(mm_bcd), 32'h0);
        chk("rst_ss", 32'(ss_bcd), 32'h0);
        chk("rst_tick", 32'(sec_tick), 32'h0);
        chk("rst_ring", 32'(ringing), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Hour wrap, minute wrap without hour carry, paired presses.
        edit(2'b01, 23, 59);
        edit(2'b01, 23, 0);
        edit(2'b01, 23, 59);
        run(60 * TD + 8);

        // Alarm 00:01: ring, then RING_MIN timeout.
        ae_lvl = 1'b1;
        edit(2'b10, 0, 1);
        edit(2'b01, 0, 0);
        run(58 * TD);
        run(3 * 60 * TD);

        // Snooze, re-ring after SNOOZE_MIN carries, then stop.
        edit(2'b01, 0, 0);
        run(62 * TD);
        step(2'b00, 0, 0, 1, 0);
        run(130 * TD);
        step(2'b00, 0, 0, 0, 1);
        run(10);

        // Snooze and stop together while ringing.
        edit(2'b01, 0, 0);
        run(62 * TD);
        step(2'b00, 0, 0, 1, 1);
        run(20);

        // Randomized episodes around a random alarm time.
        for (int ep = 0; ep < 5; ep++) begin
            ae_lvl = 1'b1;
            ah = $urandom_range(0, HM - 1);
            am = $urandom_range(0, 59);
            edit(2'b10, ah, am);
            tm = (ah * 60 + am + HM * 60 - 1) % (HM * 60);
            edit(2'b01, tm / 60, tm % 60);
            n = $urandom_range(600, 1400);
            for (int c = 0; c < n; c++) begin
                r  = $urandom_range(0, 999);
                sp = (r < 2);
                sn = (r >= 2 && r < 6);
                ih = 0;
                im = 0;
                md = 2'b00;
                if (r == 6) ae_lvl = !ae_lvl;
                if (r == 7) ae_lvl = 1'b1;
                if (r == 8) begin md = 2'b10; im = 1; end
                if (r == 9) md = 2'b01;
                if (r == 10) md = 2'b11;
                step(md, ih, im, sn, sp);
            end
        end

        @(negedge clk);
        mode = 2'b00; inc_hr = 0; inc_min = 0; snooze = 0; stop = 0;
        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("ring_exercised", 32'(ring_cycles > 0), 32'h1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
